// File: rtl/tone_seq_gen.sv
// Tone sequencer: plays one note at a time as a square wave on SPK.
// A note lasts DUR beats (0 counts as 1) and is followed by a one-beat silent gap.
// Optional feature macro TONE_OCTAVE_EN adds the OCT input to shift notes up by octaves.
module tone_seq_gen #(
   parameter int unsigned DIV_W = 11,
   parameter int unsigned DUR_W = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             TONE_CE,
   input  logic             BEAT_TICK,
   input  logic             NOTE_VLD,
   output logic             NOTE_RDY,
   input  logic [3:0]       NOTE,
`ifdef TONE_OCTAVE_EN
   input  logic [1:0]       OCT,
`endif
   input  logic [DUR_W-1:0] DUR,
   input  logic             STOP,
   output logic             SPK,
   output logic [3:0]       CODE,
   output logic             H,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StPlay = 2'd1;
   localparam logic [1:0] StGap  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] to_q, to_d;
   logic [DUR_W-1:0] dur_q, dur_d;
   logic             spk_q, spk_d;
   logic [3:0]       code_q, code_d;
   logic             h_q, h_d;
   logic             done_q, done_d;

   logic [DIV_W-1:0] to_base;
   logic [DIV_W:0]   span;
   logic [DIV_W:0]   span_sh;
   logic [DIV_W-1:0] to_new;
   logic [1:0]       oct_sel;
   logic [3:0]       code_new;
   logic             h_new;

   // 11-bit preset per note index; counter runs from preset up to all-ones
   function automatic logic [10:0] tone_tbl(input logic [3:0] n);
      logic [10:0] v;
      case (n)
         4'd0:    v = 11'h7FF;
         4'd1:    v = 11'h305;
         4'd2:    v = 11'h390;
         4'd3:    v = 11'h40C;
         4'd4:    v = 11'h45C;
         4'd5:    v = 11'h4AD;
         4'd6:    v = 11'h50A;
         4'd7:    v = 11'h55C;
         4'd8:    v = 11'h582;
         4'd9:    v = 11'h5C8;
         4'd10:   v = 11'h606;
         4'd11:   v = 11'h640;
         4'd12:   v = 11'h656;
         4'd13:   v = 11'h684;
         4'd14:   v = 11'h69A;
         default: v = 11'h6C0;
      endcase
      return v;
   endfunction

`ifdef TONE_OCTAVE_EN
   assign oct_sel = OCT;
`else
   assign oct_sel = 2'd0;
`endif

   // Preset for the incoming note, scaled to DIV_W and shifted up by oct_sel octaves
   always_comb begin
      to_base = DIV_W'(tone_tbl(NOTE)) << (DIV_W - 11);
      span    = {1'b1, {DIV_W{1'b0}}} - {1'b0, to_base};
      span_sh = span >> oct_sel;
      // Keep at least one step so the preset never wraps to zero
      if (span_sh == '0) begin
         span_sh = (DIV_W+1)'(1);
      end
      to_new = DIV_W'({1'b1, {DIV_W{1'b0}}} - span_sh);
   end

   // Solfege digit and high-octave flag for the incoming note
   always_comb begin
      code_new = 4'd0;
      h_new    = 1'b0;
      if (NOTE == 4'd0) begin
         code_new = 4'd0;
      end else if (NOTE <= 4'd7) begin
         code_new = NOTE;
      end else if (NOTE <= 4'd14) begin
         code_new = NOTE - 4'd7;
         h_new    = 1'b1;
      end else begin
         code_new = 4'd1;
         h_new    = 1'b1;
      end
   end

   // Sequencer next state: STOP beats BEAT_TICK, which beats TONE_CE
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      dur_d   = dur_q;
      spk_d   = spk_q;
      code_d  = code_q;
      h_d     = h_q;
      done_d  = 1'b0;
      case (state_q)
         StIdle: begin
            if (NOTE_VLD && !STOP) begin
               state_d = StPlay;
               to_d    = to_new;
               cnt_d   = to_new;
               dur_d   = (DUR == '0) ? DUR_W'(1) : DUR;
               spk_d   = 1'b0;
               code_d  = code_new;
               h_d     = h_new;
            end
         end
         StPlay: begin
            if (STOP) begin
               state_d = StIdle;
               spk_d   = 1'b0;
            end else if (BEAT_TICK && (dur_q <= DUR_W'(1))) begin
               state_d = StGap;
               dur_d   = '0;
               spk_d   = 1'b0;
            end else begin
               if (BEAT_TICK) begin
                  dur_d = dur_q - DUR_W'(1);
               end
               if (TONE_CE) begin
                  if (&cnt_q) begin
                     cnt_d = to_q;
                     // Rests keep counting but never drive the speaker
                     if (code_q != 4'd0) begin
                        spk_d = ~spk_q;
                     end
                  end else begin
                     cnt_d = cnt_q + DIV_W'(1);
                  end
               end
            end
         end
         StGap: begin
            spk_d = 1'b0;
            if (STOP) begin
               state_d = StIdle;
            end else if (BEAT_TICK) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            spk_d   = 1'b0;
         end
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         to_q    <= '0;
         dur_q   <= '0;
         spk_q   <= 1'b0;
         code_q  <= 4'd0;
         h_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
         dur_q   <= dur_d;
         spk_q   <= spk_d;
         code_q  <= code_d;
         h_q     <= h_d;
         done_q  <= done_d;
      end
   end

   assign NOTE_RDY = (state_q == StIdle);
   assign BUSY     = (state_q == StPlay) || (state_q == StGap);
   assign SPK      = spk_q;
   assign CODE     = code_q;
   assign H        = h_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_tone_seq_gen.sv
// Directed bench for tone_seq_gen (DIV_W=11, DUR_W=4); OCT test only with TONE_OCTAVE_EN.
module tb_tone_seq_gen;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       TONE_CE = 1'b0;
   logic       BEAT_TICK = 1'b0;
   logic       NOTE_VLD = 1'b0;
   logic       NOTE_RDY;
   logic [3:0] NOTE = 4'd0;
   logic [3:0] DUR = 4'd0;
   logic       STOP = 1'b0;
   logic       SPK;
   logic [3:0] CODE;
   logic       H;
   logic       BUSY;
   logic       DONE;
`ifdef TONE_OCTAVE_EN
   logic [1:0] OCT = 2'd0;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   tone_seq_gen #(.DIV_W(11), .DUR_W(4)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .TONE_CE   (TONE_CE),
      .BEAT_TICK (BEAT_TICK),
      .NOTE_VLD  (NOTE_VLD),
      .NOTE_RDY  (NOTE_RDY),
      .NOTE      (NOTE),
`ifdef TONE_OCTAVE_EN
      .OCT       (OCT),
`endif
      .DUR       (DUR),
      .STOP      (STOP),
      .SPK       (SPK),
      .CODE      (CODE),
      .H         (H),
      .BUSY      (BUSY),
      .DONE      (DONE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic beat();
      BEAT_TICK = 1'b1;
      step();
      BEAT_TICK = 1'b0;
   endtask

   task automatic accept(input logic [3:0] n, input logic [3:0] d, input logic tick);
      NOTE      = n;
      DUR       = d;
      NOTE_VLD  = 1'b1;
      BEAT_TICK = tick;
      step();
      NOTE_VLD  = 1'b0;
      BEAT_TICK = 1'b0;
   endtask

   // Edges until SPK changes; 5000 means it never did
   task automatic measure(output int n);
      logic start;
      start = SPK;
      n = 0;
      while (SPK == start && n < 5000) begin
         step();
         n++;
      end
   endtask

   // Run n edges and report whether SPK was ever high
   task automatic quiet(input int n, output logic seen_hi);
      seen_hi = 1'b0;
      for (int i = 0; i < n; i++) begin
         step();
         if (SPK) seen_hi = 1'b1;
      end
   endtask

   int   half;
   logic hi;
   logic [3:0] map_note [4] = '{4'd7, 4'd8, 4'd14, 4'd15};
   logic [3:0] map_code [4] = '{4'd7, 4'd1, 4'd7, 4'd1};
   logic       map_h    [4] = '{1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      // Reset values
      step();
      step();
      check("rst_rdy", NOTE_RDY, 1);
      check("rst_spk", SPK, 0);
      check("rst_code", CODE, 0);
      check("rst_h", H, 0);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      RST_N = 1'b1;
      TONE_CE = 1'b1;
      step();

      // NOTE=1 DUR=2, beat on accept cycle ignored; half-period 2048-0x305 = 1275
      accept(4'd1, 4'd2, 1'b1);
      check("a_busy", BUSY, 1);
      check("a_rdy", NOTE_RDY, 0);
      check("a_code", CODE, 1);
      check("a_h", H, 0);
      check("a_spk0", SPK, 0);
      measure(half);
      check("a_half1", half, 1275);
      measure(half);
      check("a_half2", half, 1275);
      measure(half);
      check("a_half3", half, 1275);
      check("a_spk_hi", SPK, 1);
      beat();
      check("a_b1_busy", BUSY, 1);
      check("a_b1_done", DONE, 0);
      step();
      step();
      beat();
      check("a_b2_spk", SPK, 0);
      check("a_b2_busy", BUSY, 1);
      check("a_b2_done", DONE, 0);
      quiet(1300, hi);
      check("a_gap_quiet", hi, 0);
      check("a_gap_busy", BUSY, 1);
      beat();
      check("a_b3_done", DONE, 1);
      check("a_b3_busy", BUSY, 0);
      check("a_b3_rdy", NOTE_RDY, 1);
      step();
      check("a_done_pulse", DONE, 0);
      check("a_code_hold", CODE, 1);

      // Rest: NOTE=0 DUR=1
      accept(4'd0, 4'd1, 1'b0);
      check("r_code", CODE, 0);
      check("r_busy", BUSY, 1);
      quiet(3000, hi);
      check("r_quiet", hi, 0);
      beat();
      check("r_gap_busy", BUSY, 1);
      check("r_gap_done", DONE, 0);
      beat();
      check("r_done", DONE, 1);
      check("r_busy_end", BUSY, 0);

      // NOTE=9 DUR=0: CODE 2 high, half-period 2048-0x5C8 = 568, one beat long
      accept(4'd9, 4'd0, 1'b0);
      check("n9_code", CODE, 2);
      check("n9_h", H, 1);
      measure(half);
      check("n9_half1", half, 568);
      measure(half);
      check("n9_half2", half, 568);
      beat();
      check("n9_gap_busy", BUSY, 1);
      check("n9_gap_spk", SPK, 0);
      beat();
      check("n9_done", DONE, 1);

      // STOP mid-PLAY with SPK high (NOTE=5 half-period 2048-0x4AD = 851)
      accept(4'd5, 4'd3, 1'b0);
      measure(half);
      check("s_half", half, 851);
      STOP = 1'b1;
      step();
      check("s_rdy", NOTE_RDY, 1);
      check("s_busy", BUSY, 0);
      check("s_spk", SPK, 0);
      check("s_done", DONE, 0);
      // STOP in IDLE blocks acceptance
      NOTE_VLD = 1'b1;
      NOTE     = 4'd3;
      step();
      NOTE_VLD = 1'b0;
      check("s_block_busy", BUSY, 0);
      check("s_block_code", CODE, 5);
      STOP = 1'b0;
      step();
      check("s_no_done", DONE, 0);

      // STOP during GAP: no DONE
      accept(4'd3, 4'd1, 1'b0);
      beat();
      check("sg_busy", BUSY, 1);
      STOP = 1'b1;
      step();
      STOP = 1'b0;
      check("sg_rdy", NOTE_RDY, 1);
      check("sg_done", DONE, 0);
      step();
      check("sg_done2", DONE, 0);

      // CODE/H mapping for upper notes
      for (int i = 0; i < 4; i++) begin
         accept(map_note[i], 4'd1, 1'b0);
         check($sformatf("map_code_%0d", map_note[i]), CODE, map_code[i]);
         check($sformatf("map_h_%0d", map_note[i]), H, map_h[i]);
         STOP = 1'b1;
         step();
         STOP = 1'b0;
      end

      // Reset mid-note with SPK high (NOTE=12 half-period 2048-0x656 = 426)
      accept(4'd12, 4'd4, 1'b0);
      measure(half);
      check("rm_half", half, 426);
      RST_N = 1'b0;
      step();
      check("rm_spk", SPK, 0);
      check("rm_code", CODE, 0);
      check("rm_h", H, 0);
      check("rm_busy", BUSY, 0);
      check("rm_done", DONE, 0);
      check("rm_rdy", NOTE_RDY, 1);
      RST_N = 1'b1;
      step();
      check("rm_done2", DONE, 0);

`ifdef TONE_OCTAVE_EN
      // One octave up: (2048-0x305)>>1 = 637
      OCT = 2'd1;
      accept(4'd1, 4'd1, 1'b0);
      OCT = 2'd0;
      measure(half);
      check("oct_half1", half, 637);
      measure(half);
      check("oct_half2", half, 637);
      STOP = 1'b1;
      step();
      STOP = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
